// File: rtl/traffic_light_pkg.sv
// Shared lamp/error bit indices, phase encoding and small decode helpers for the lamp monitor.
package traffic_light_pkg;

  localparam int unsigned LAMP_W   = 3;
  localparam int unsigned LAMP_RED = 2;
  localparam int unsigned LAMP_YEL = 1;
  localparam int unsigned LAMP_GRN = 0;

  localparam int unsigned ERR_W      = 3;
  localparam int unsigned ERR_ONEHOT = 2;
  localparam int unsigned ERR_SEQ    = 1;
  localparam int unsigned ERR_DWELL  = 0;

  localparam int unsigned DWELL_W = 8;
  localparam int unsigned CYCLE_W = 8;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_RED  = 2'd1,
    PH_GRN  = 2'd2,
    PH_YEL  = 2'd3
  } phase_t;

  // Lamp pattern that keeps the FSM in the given phase.
  function automatic logic [LAMP_W-1:0] phase_lamp(input phase_t ph);
    logic [LAMP_W-1:0] l;
    l = '0;
    case (ph)
      PH_RED:  l[LAMP_RED] = 1'b1;
      PH_GRN:  l[LAMP_GRN] = 1'b1;
      PH_YEL:  l[LAMP_YEL] = 1'b1;
      default: l = '0;
    endcase
    return l;
  endfunction

  // Only legal successor of each locked phase.
  function automatic phase_t phase_succ(input phase_t ph);
    phase_t n;
    case (ph)
      PH_RED:  n = PH_GRN;
      PH_GRN:  n = PH_YEL;
      PH_YEL:  n = PH_RED;
      default: n = PH_SYNC;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tlm_dwell_counter.sv
// Per-phase dwell counter: clear, load-1 on phase entry, saturating increment, target compare.
module tlm_dwell_counter
  import traffic_light_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               zero,
  input  logic               load,
  input  logic               inc,
  input  logic [DWELL_W-1:0] target,
  output logic               hit_c
);

  localparam logic [DWELL_W-1:0] SAT = '1;

  logic [DWELL_W-1:0] count;

  // Count cycles spent in the current phase; zero has priority over load over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (zero) begin
      count <= '0;
    end else if (load) begin
      count <= DWELL_W'(1);
    end else if (inc && (count != SAT)) begin
      count <= count + DWELL_W'(1);
    end
  end

  // Current dwell equals the required dwell of the phase being held.
  assign hit_c = (count == target);

endmodule

// File: rtl/traffic_light_monitor.sv
// Observes a 3-lamp bus, locks onto the RED->GRN->YEL cycle and flags onehot, sequence and dwell errors.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_CYC = 5,
  parameter int unsigned GRN_CYC = 4,
  parameter int unsigned YEL_CYC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LAMP_W-1:0]  light,
  input  logic               clear,
  output logic [1:0]         phase,
  output logic               locked,
  output logic [ERR_W-1:0]   err_pulse,
  output logic [ERR_W-1:0]   err_sticky,
  output logic [CYCLE_W-1:0] cycle_count
);

  phase_t             state, state_nxt;
  logic               unchecked, unchecked_nxt;
  logic               overstay, overstay_nxt;
  logic [ERR_W-1:0]   pulse_nxt;
  logic [CYCLE_W-1:0] count_nxt;
  logic               dw_zero, dw_load, dw_inc, dw_hit_c;
  logic [DWELL_W-1:0] dw_target;

  tlm_dwell_counter u_dwell (
    .clk    (clk),
    .reset  (reset),
    .zero   (dw_zero),
    .load   (dw_load),
    .inc    (dw_inc),
    .target (dw_target),
    .hit_c  (dw_hit_c)
  );

  // Required dwell of the phase currently held.
  always_comb begin
    dw_target = '0;
    case (state)
      PH_RED:  dw_target = DWELL_W'(RED_CYC);
      PH_GRN:  dw_target = DWELL_W'(GRN_CYC);
      PH_YEL:  dw_target = DWELL_W'(YEL_CYC);
      default: dw_target = '0;
    endcase
  end

  // Next-state, error strobe and counter decisions from the current light sample.
  always_comb begin
    state_nxt     = state;
    unchecked_nxt = unchecked;
    overstay_nxt  = overstay;
    pulse_nxt     = '0;
    count_nxt     = cycle_count;
    dw_zero       = 1'b0;
    dw_load       = 1'b0;
    dw_inc        = 1'b0;
    if (!$onehot(light)) begin
      pulse_nxt[ERR_ONEHOT] = 1'b1;
      state_nxt             = PH_SYNC;
      dw_zero               = 1'b1;
    end else if (state == PH_SYNC) begin
      // First RED after sync is accepted without any dwell check.
      if (light[LAMP_RED]) begin
        state_nxt     = PH_RED;
        dw_load       = 1'b1;
        unchecked_nxt = 1'b1;
        overstay_nxt  = 1'b0;
      end
    end else if (light == phase_lamp(state)) begin
      dw_inc = 1'b1;
      if (!unchecked && !overstay && dw_hit_c) begin
        pulse_nxt[ERR_DWELL] = 1'b1;
        overstay_nxt         = 1'b1;
      end
    end else if (light == phase_lamp(phase_succ(state))) begin
      // An overstay already reported this phase suppresses the exit check.
      if (!unchecked && !overstay && !dw_hit_c) begin
        pulse_nxt[ERR_DWELL] = 1'b1;
      end
      if (state == PH_YEL) begin
        count_nxt = cycle_count + CYCLE_W'(1);
      end
      state_nxt     = phase_succ(state);
      dw_load       = 1'b1;
      unchecked_nxt = 1'b0;
      overstay_nxt  = 1'b0;
    end else begin
      pulse_nxt[ERR_SEQ] = 1'b1;
      state_nxt          = PH_SYNC;
      dw_zero            = 1'b1;
    end
  end

  // Register FSM state and all outputs; a new pulse beats a coincident clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= PH_SYNC;
      unchecked   <= 1'b0;
      overstay    <= 1'b0;
      locked      <= 1'b0;
      err_pulse   <= '0;
      err_sticky  <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      unchecked   <= unchecked_nxt;
      overstay    <= overstay_nxt;
      locked      <= (state_nxt != PH_SYNC);
      err_pulse   <= pulse_nxt;
      err_sticky  <= clear ? pulse_nxt : (err_sticky | pulse_nxt);
      cycle_count <= count_nxt;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor with default dwell parameters.
module tb_traffic_light_monitor;

  logic       clk;
  logic       reset;
  logic [2:0] light;
  logic       clear;
  logic [1:0] phase;
  logic       locked;
  logic [2:0] err_pulse;
  logic [2:0] err_sticky;
  logic [7:0] cycle_count;

  int n_cmp;
  int n_bad;

  traffic_light_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .light       (light),
    .clear       (clear),
    .phase       (phase),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_sticky  (err_sticky),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample, let it be captured, then settle 1 ns past the edge.
  task automatic drive(input logic [2:0] l, input logic c);
    light = l;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    light = 3'b000;
    clear = 1'b0;
    #2;
    n_cmp++;
    if ({phase, locked, err_pulse, err_sticky, cycle_count} !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_early: got %h expected 0", {phase, locked, err_pulse, err_sticky, cycle_count});
    end
    #9;
    n_cmp++;
    if ({phase, locked, err_pulse, err_sticky, cycle_count} !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_held: got %h expected 0", {phase, locked, err_pulse, err_sticky, cycle_count});
    end
    #1;
    reset = 1'b1;
  endtask

  task automatic test_clean_round();
    logic [2:0] lt [12];
    logic [1:0] ph [12];
    lt = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b001,
           3'b010, 3'b010, 3'b100};
    ph = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1};
    for (int i = 0; i < 12; i++) begin
      drive(lt[i], 1'b0);
      n_cmp++;
      if ({phase, locked, err_pulse} !== {ph[i], 1'b1, 3'b000}) begin
        n_bad++;
        $display("FAIL clean_step%0d: phase/locked/pulse got %b expected %b", i,
                 {phase, locked, err_pulse}, {ph[i], 1'b1, 3'b000});
      end
    end
    n_cmp++;
    if (cycle_count !== 8'd1 || err_sticky !== 3'b000) begin
      n_bad++;
      $display("FAIL clean_round: count=%0d sticky=%b expected count=1 sticky=000", cycle_count, err_sticky);
    end
  endtask

  task automatic test_grn_overstay();
    for (int i = 0; i < 4; i++) drive(3'b100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(3'b001, 1'b0);
      n_cmp++;
      if (err_pulse !== ((i == 4) ? 3'b001 : 3'b000)) begin
        n_bad++;
        $display("FAIL overstay_grn%0d: err_pulse got %b expected %b", i, err_pulse,
                 (i == 4) ? 3'b001 : 3'b000);
      end
    end
    drive(3'b010, 1'b0);
    n_cmp++;
    if ({phase, err_pulse, err_sticky} !== {2'd3, 3'b000, 3'b001}) begin
      n_bad++;
      $display("FAIL overstay_exit: phase/pulse/sticky got %b expected %b",
               {phase, err_pulse, err_sticky}, {2'd3, 3'b000, 3'b001});
    end
    drive(3'b010, 1'b1);
    n_cmp++;
    if (err_sticky !== 3'b000) begin
      n_bad++;
      $display("FAIL clear_sticky: got %b expected 000", err_sticky);
    end
    drive(3'b100, 1'b0);
    n_cmp++;
    if (phase !== 2'd1 || cycle_count !== 8'd2) begin
      n_bad++;
      $display("FAIL overstay_round: phase=%0d count=%0d expected phase=1 count=2", phase, cycle_count);
    end
  endtask

  task automatic test_onehot();
    drive(3'b100, 1'b0);
    drive(3'b110, 1'b0);
    n_cmp++;
    if ({phase, locked, err_pulse, err_sticky} !== {2'd0, 1'b0, 3'b100, 3'b100}) begin
      n_bad++;
      $display("FAIL onehot_err: phase/locked/pulse/sticky got %b expected %b",
               {phase, locked, err_pulse, err_sticky}, {2'd0, 1'b0, 3'b100, 3'b100});
    end
    drive(3'b100, 1'b0);
    n_cmp++;
    if ({phase, locked, err_pulse} !== {2'd1, 1'b1, 3'b000}) begin
      n_bad++;
      $display("FAIL onehot_relock: got %b expected %b", {phase, locked, err_pulse}, {2'd1, 1'b1, 3'b000});
    end
  endtask

  task automatic test_sequence();
    drive(3'b010, 1'b0);
    n_cmp++;
    if ({phase, err_pulse, err_sticky} !== {2'd0, 3'b010, 3'b110}) begin
      n_bad++;
      $display("FAIL seq_err: phase/pulse/sticky got %b expected %b",
               {phase, err_pulse, err_sticky}, {2'd0, 3'b010, 3'b110});
    end
    drive(3'b010, 1'b0);
    drive(3'b001, 1'b0);
    n_cmp++;
    if ({phase, locked, err_pulse} !== {2'd0, 1'b0, 3'b000}) begin
      n_bad++;
      $display("FAIL seq_ignore: got %b expected %b", {phase, locked, err_pulse}, {2'd0, 1'b0, 3'b000});
    end
    drive(3'b100, 1'b0);
    drive(3'b100, 1'b1);
    n_cmp++;
    if ({phase, err_sticky} !== {2'd1, 3'b000}) begin
      n_bad++;
      $display("FAIL seq_relock: phase/sticky got %b expected %b", {phase, err_sticky}, {2'd1, 3'b000});
    end
  endtask

  task automatic test_short_yel();
    for (int i = 0; i < 4; i++) drive(3'b001, 1'b0);
    drive(3'b010, 1'b0);
    n_cmp++;
    if (err_pulse !== 3'b000) begin
      n_bad++;
      $display("FAIL short_grn_exit: err_pulse got %b expected 000", err_pulse);
    end
    drive(3'b100, 1'b0);
    n_cmp++;
    if ({phase, locked, err_pulse, cycle_count} !== {2'd1, 1'b1, 3'b001, 8'd3}) begin
      n_bad++;
      $display("FAIL short_yel_exit: phase/locked/pulse/count got %b expected %b",
               {phase, locked, err_pulse, cycle_count}, {2'd1, 1'b1, 3'b001, 8'd3});
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 253; r++) begin
      for (int i = 0; i < 4; i++) drive(3'b100, (r == 0) && (i == 0));
      for (int i = 0; i < 4; i++) drive(3'b001, 1'b0);
      for (int i = 0; i < 2; i++) drive(3'b010, 1'b0);
      drive(3'b100, 1'b0);
      if (r == 251) begin
        n_cmp++;
        if (cycle_count !== 8'd255) begin
          n_bad++;
          $display("FAIL wrap_255: count got %0d expected 255", cycle_count);
        end
      end
    end
    n_cmp++;
    if (cycle_count !== 8'd0 || err_sticky !== 3'b000) begin
      n_bad++;
      $display("FAIL wrap_0: count=%0d sticky=%b expected count=0 sticky=000", cycle_count, err_sticky);
    end
  endtask

  task automatic test_clear_vs_error();
    for (int i = 0; i < 3; i++) drive(3'b100, 1'b0);
    drive(3'b001, 1'b1);
    n_cmp++;
    if ({phase, err_pulse, err_sticky} !== {2'd2, 3'b001, 3'b001}) begin
      n_bad++;
      $display("FAIL clear_vs_err: phase/pulse/sticky got %b expected %b",
               {phase, err_pulse, err_sticky}, {2'd2, 3'b001, 3'b001});
    end
  endtask

  task automatic test_async_reset();
    drive(3'b001, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({phase, locked, err_pulse, err_sticky, cycle_count} !== 17'h0) begin
      n_bad++;
      $display("FAIL async_reset: got %h expected 0", {phase, locked, err_pulse, err_sticky, cycle_count});
    end
    #4;
    reset = 1'b1;
    drive(3'b001, 1'b0);
    n_cmp++;
    if ({phase, locked, err_pulse} !== {2'd0, 1'b0, 3'b000}) begin
      n_bad++;
      $display("FAIL post_reset_grn: got %b expected %b", {phase, locked, err_pulse}, {2'd0, 1'b0, 3'b000});
    end
    drive(3'b100, 1'b0);
    n_cmp++;
    if ({phase, locked, err_pulse} !== {2'd1, 1'b1, 3'b000}) begin
      n_bad++;
      $display("FAIL post_reset_relock: got %b expected %b", {phase, locked, err_pulse}, {2'd1, 1'b1, 3'b000});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_clean_round();
    test_grn_overstay();
    test_onehot();
    test_sequence();
    test_short_yel();
    test_wrap();
    test_clear_vs_error();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
